// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse receiver: FSM states, error codes, parity helper.
// No logic of its own; no latency; no flow control.
// Imported by ps2_line_sync and mouse_receiver.
package mouse_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic parity_error(input logic [7:0] data_byte, input logic par_bit);
        return ~^{data_byte, par_bit};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-flop synchroniser (idle-high reset), optional glitch filter, falling-edge flag.
// Latency: 2 cycles sync, plus FILTER_LEN cycles when FILTER_EN; fall_o is combinational on the conditioned line.
// No backpressure: samples every cycle.
module ps2_line_sync
    import mouse_pkg::*;
#(
    parameter bit FILTER_EN  = 1'b0,
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);

    logic           sync1_q, sync2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           prev_q;
    logic           line_c;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Output follows the input only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (sync2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FCNT_LAST) begin
            filt_d = sync2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign line_c = FILTER_EN ? filt_q : sync2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= line_c;
        end
    end

    assign line_o = line_c;
    assign fall_o = prev_q & ~line_c;

endmodule

// File: rtl/mouse_receiver.sv
// Host-side PS/2 receiver: 11-bit device->host frames to a byte, error code and one-cycle BYTE_READY strobe.
// Latency: BYTE_READY one cycle after the stop-bit edge is flagged (MOUSE_CLK_FILTER_EN adds FILTER_LEN cycles).
// No backpressure: READ_ENABLE low forces IDLE and ignores the bus; outputs are held until the next frame.
module mouse_receiver
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

`ifdef MOUSE_CLK_FILTER_EN
    localparam bit CLK_FILTER_EN = 1'b1;
`else
    localparam bit CLK_FILTER_EN = 1'b0;
`endif

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          ms_fall;
    logic          ms_dat;
    logic          unused_ms_clk;
    logic          unused_dat_fall;
    logic          edge_en;
    logic          in_frame;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic [7:0]    byte_q, byte_d;
    logic [1:0]    err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    ps2_line_sync #(
        .FILTER_EN  (CLK_FILTER_EN),
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_sync (
        .clk_i   (CLK),
        .rst_n_i (RESET_N),
        .line_i  (CLK_MOUSE_IN),
        .line_o  (unused_ms_clk),
        .fall_o  (ms_fall)
    );

    ps2_line_sync #(
        .FILTER_EN  (1'b0),
        .FILTER_LEN (FILTER_LEN)
    ) u_dat_sync (
        .clk_i   (CLK),
        .rst_n_i (RESET_N),
        .line_i  (DATA_MOUSE_IN),
        .line_o  (ms_dat),
        .fall_o  (unused_dat_fall)
    );

    assign edge_en  = ms_fall & READ_ENABLE;
    assign in_frame = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        byte_d    = byte_q;
        err_d     = err_q;
        tmo_d     = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (edge_en && !ms_dat) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (edge_en) begin
                    shift_d[cnt_q] = ms_dat;
                    if (cnt_q == 3'd7) begin
                        cnt_d   = '0;
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (edge_en) begin
                    par_err_d = parity_error(shift_q, ms_dat);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (edge_en) begin
                    byte_d  = shift_q;
                    err_d   = {~ms_dat, par_err_q};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An edge in the terminal cycle keeps the frame alive.
        if (in_frame && !edge_en) begin
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (!READ_ENABLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            byte_q    <= '0;
            err_q     <= ERR_NONE;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = (state_q == DONE) && READ_ENABLE;

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver: table of frames plus hand-written timeout, enable, reset and glitch sequences.
module tb_mouse_receiver;
    import mouse_pkg::*;

    localparam int TMO  = 200;
    localparam int HALF = 20;
    localparam int NVEC = 7;

    logic       clk;
    logic       rst_n;
    logic       ms_clk;
    logic       ms_dat;
    logic       re;
    logic [7:0] byte_read;
    logic [1:0] byte_code;
    logic       byte_ready;

    int         n_cmp;
    int         n_bad;
    int         rdy_total;
    logic [7:0] cap_byte;
    logic [1:0] cap_code;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stp;
        logic [7:0] exp_b;
        logic [1:0] exp_c;
    } vec_t;

    vec_t tbl [NVEC];

    mouse_receiver #(
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (4)
    ) dut (
        .CLK             (clk),
        .RESET_N         (rst_n),
        .CLK_MOUSE_IN    (ms_clk),
        .DATA_MOUSE_IN   (ms_dat),
        .READ_ENABLE     (re),
        .BYTE_READ       (byte_read),
        .BYTE_ERROR_CODE (byte_code),
        .BYTE_READY      (byte_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rdy_total = 0;
    always @(negedge clk) begin
        if (byte_ready) begin
            rdy_total <= rdy_total + 1;
            cap_byte  <= byte_read;
            cap_code  <= byte_code;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ms_dat = b;
        repeat (HALF / 2) @(posedge clk);
        ms_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ms_clk = 1'b1;
        repeat (HALF / 2) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_bit(f[i]);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic run_frame(input string name, input logic [7:0] d, input logic p, input logic s,
                             input logic [7:0] exp_b, input logic [1:0] exp_c);
        int base;
        base = rdy_total;
        send_bits(mk_frame(d, p, s), 0, 10);
        ms_dat = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check({name, " strobe count"}, 32'(rdy_total - base), 32'd1);
        check({name, " byte"}, 32'(cap_byte), 32'(exp_b));
        check({name, " code"}, 32'(cap_code), 32'(exp_c));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [2:0] exp_st;

        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{8'hFA, 1'b1, 1'b1, 8'hFA, 2'b00};
        tbl[1] = '{8'hAA, 1'b0, 1'b1, 8'hAA, 2'b01};
        tbl[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 2'b10};
        tbl[3] = '{8'h55, 1'b1, 1'b1, 8'h55, 2'b00};
        tbl[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 2'b00};
        tbl[5] = '{8'h07, 1'b1, 1'b0, 8'h07, 2'b11};
        tbl[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 2'b00};

        rst_n  = 1'b0;
        ms_clk = 1'b1;
        ms_dat = 1'b1;
        re     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset byte", 32'(byte_read), 32'h0);
        check("reset code", 32'(byte_code), 32'h0);
        check("reset ready", 32'(byte_ready), 32'h0);
        check("reset state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int v = 0; v < NVEC; v++) begin
            run_frame($sformatf("vec%0d", v), tbl[v].d, tbl[v].par, tbl[v].stp,
                      tbl[v].exp_b, tbl[v].exp_c);
        end

        // Start bit plus four data bits, then the mouse clock stops.
        base = rdy_total;
        send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 0, 4);
        ms_dat = 1'b1;
        repeat (TMO + 50) @(posedge clk);
        @(negedge clk);
        check("timeout strobe count", 32'(rdy_total - base), 32'd0);
        check("timeout state", 32'(dut.state_q), 32'(IDLE));
        check("timeout byte held", 32'(byte_read), 32'hFF);
        run_frame("after timeout", 8'h08, 1'b0, 1'b1, 8'h08, 2'b00);

        // Enable dropped after five data bits; rest of the frame arrives while disabled.
        base = rdy_total;
        send_bits(mk_frame(8'h3C, 1'b1, 1'b1), 0, 5);
        re = 1'b0;
        repeat (5) @(posedge clk);
        send_bits(mk_frame(8'h3C, 1'b1, 1'b1), 6, 10);
        re = 1'b1;
        ms_dat = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("disable strobe count", 32'(rdy_total - base), 32'd0);
        check("disable byte held", 32'(byte_read), 32'h08);
        run_frame("after enable", 8'h14, 1'b1, 1'b1, 8'h14, 2'b00);

        // Reset mid-frame clears everything; a following frame is received cleanly.
        send_bits(mk_frame(8'hC3, 1'b1, 1'b1), 0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset byte", 32'(byte_read), 32'h0);
        check("midreset code", 32'(byte_code), 32'h0);
        check("midreset state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        ms_dat = 1'b1;
        repeat (5) @(posedge clk);
        run_frame("after midreset", 8'hC3, 1'b1, 1'b1, 8'hC3, 2'b00);

        // Two-cycle low glitch on the mouse clock while data is low.
        ms_dat = 1'b0;
        repeat (4) @(posedge clk);
        ms_clk = 1'b0;
        repeat (2) @(posedge clk);
        ms_clk = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
`ifdef MOUSE_CLK_FILTER_EN
        exp_st = IDLE;
`else
        exp_st = DATA;
`endif
        check("glitch state", 32'(dut.state_q), 32'(exp_st));
        ms_dat = 1'b1;
        repeat (TMO + 50) @(posedge clk);
        @(negedge clk);
        check("glitch recovered state", 32'(dut.state_q), 32'(IDLE));
        run_frame("after glitch", 8'h81, 1'b1, 1'b1, 8'h81, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
